us_gray_2x: RTL
===============

# us_gray_2x

Reconstructs a full-resolution video stream from a 2:1 decimated stream by 2x2 nearest-neighbour pixel replication. It is the inverse stage of the downscaler path and sits at the display end of the pipeline. The input keeps full-resolution sync and active-window timing and marks retained samples with a valid strobe. A half-width line buffer replays even lines onto odd lines.

## Interface
- WIDTH, 10, bits per colour channel
- H_ACT, 640, maximum active pixels per line (even); line buffer depth H_ACT/2
- clk  input  1  pixel clock
- rstn  input  1  reset; one clock, reset is asynchronous and active-low
- i_vsync  input  1  frame sync, active-high
- i_hsync  input  1  line sync, active-high
- i_de  input  1  full-resolution active window
- i_valid  input  1  retained sample present (even column of even line, inside i_de)
- i_r_data / i_g_data / i_b_data  input  WIDTH  retained sample channels
- o_vsync / o_hsync / o_de  output  1  inputs delayed 1 cycle
- o_r_data / o_g_data / o_b_data  output  WIDTH  replicated pixel
- o_err  output  1  sticky protocol error (see Configuration)

## Operation
- Column counter col: 0 on first i_de cycle of a line; increments per i_de cycle; saturates at H_ACT.
- Row parity odd: cleared on i_vsync rising edge; toggles on i_de falling edge.
- Even row, even col, i_valid=1: output = input sample; hold register = sample; buffer[col>>1] = sample.
- Even row, even col, i_valid=0: output = hold register; buffer is not written.
- Even row, odd col: output = hold register.
- Odd row: output = buffer[col>>1] for every col; i_valid is ignored.
- col >= H_ACT: no buffer write/read; output = hold register (even row) or last read word (odd row).
- Odd line width: last even pixel is emitted once; no padding is added.
- Outside i_de: data outputs are 0.
- The buffer holds 3*WIDTH bits per word ({r,g,b}), single port, synchronous read. Contents are not cleared by reset.

## Timing
- Latency: exactly 1 cycle for sync, de and data. Every output = function of inputs at cycle n, registered at n+1.
- Buffer read address is driven from the cycle-n col, so read data aligns with registered sync at n+1.
- On a write and read to the same address in the same cycle, the write wins (even rows only write; odd rows only read, so this does not occur).
- Reset values: all outputs 0; col=0; odd=0; hold register 0; o_err 0.
- Reset mid-line: state is cleared immediately. The next line starts as an even row regardless of frame position. Odd rows before the next even row read stale buffer data; this is accepted.
- Coincident i_vsync rise and i_de fall: the vsync clear wins (odd=0).

## Configuration
- US_ERR_CHK_EN defined: o_err is set sticky when any of the following occur:
  - i_valid=1 with i_de=0
  - i_valid=1 on an odd col or odd row
  - i_valid=0 on an even col of an even row with col<H_ACT
  
  o_err clears on i_vsync rising edge, with set taking priority in the same cycle. It asserts 1 cycle after the offending input.
- US_ERR_CHK_EN undefined: o_err is constant 0 and the checker logic is absent.

## Structure
- Shared package us_pkg: typedef rgb_t (packed struct of r, g, b, each WIDTH bits), localparam BUF_DEPTH = H_ACT/2, and the address width $clog2(BUF_DEPTH).
- One sub-module: us_line_buf. It is a single-port synchronous-read RAM of rgb_t with ports clk, we, addr, wdata, rdata.
- Counters, parity, hold register and error checker stay in the top.

## Test plan
- 4x4 active frame, even row samples (10,20,30),(40,50,60) -> rows 0–3 each output 10,10,40,40 on r; g and b follow likewise; o_de equals i_de delayed 1.
- Reset asserted at col 2 of row 1, released for the next line -> outputs 0 during reset; next line is treated as even and replicates fresh input.
- Line of H_ACT+4 active cycles -> last 4 outputs repeat the pixel at col H_ACT-2; no buffer corruption on the following odd row.
- Odd width 5 with samples at cols 0,2,4 = 1,2,3 -> even row outputs 1,1,2,2,3; odd row outputs 1,1,2,2,3.
- With US_ERR_CHK_EN, i_valid at col 1 of row 0 -> o_err=1 from the next cycle until the next i_vsync rise; without the macro, o_err stays 0.
- Two consecutive frames with different content -> row parity restarts at the vsync rise; the first line of frame 2 uses new samples, not the buffer.

Source files
------------

// File: rtl/us_pkg.sv
// Shared sizing and pixel type for the 2x nearest-neighbour upscaler.
package us_pkg;

    localparam int WIDTH     = 10;
    localparam int H_ACT     = 640;
    localparam int BUF_DEPTH = H_ACT / 2;
    localparam int ADDR_W    = $clog2(BUF_DEPTH);
    localparam int COL_W     = $clog2(H_ACT + 1);

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] b;
    } rgb_t;

endpackage

// File: rtl/us_line_buf.sv
// Half-width line store: single port, synchronous read; a write returns the written word.
module us_line_buf
    import us_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  rgb_t              wdata,
    output rgb_t              rdata
);

    rgb_t mem_q [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
            rdata       <= wdata;
        end else begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/us_gray_2x.sv
// 2x2 nearest-neighbour upscaler: even lines repeat retained samples and store them,
// odd lines replay the stored line. Optional protocol checker: US_ERR_CHK_EN.
module us_gray_2x
    import us_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_r_data,
    input  logic [WIDTH-1:0] i_g_data,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [WIDTH-1:0] o_r_data,
    output logic [WIDTH-1:0] o_g_data,
    output logic [WIDTH-1:0] o_b_data,
    output logic             o_err
);

    logic [COL_W-1:0]  col_q, col_d;
    logic              odd_q, odd_d;
    logic              vs_q, hs_q, de_q;
    logic              ram_sel_q, ram_sel_d;
    rgb_t              hold_q, hold_d;
    rgb_t              pix_q, pix_d;
    rgb_t              sample, rd_data, out_px;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic              in_range, vs_rise, de_fall;

    assign sample   = '{r: i_r_data, g: i_g_data, b: i_b_data};
    assign in_range = (col_q < COL_W'(H_ACT));
    assign vs_rise  = i_vsync & ~vs_q;
    assign de_fall  = ~i_de & de_q;

    always_comb begin
        col_d = '0;
        if (i_de) begin
            col_d = (col_q == COL_W'(H_ACT)) ? col_q : col_q + 1'b1;
        end

        odd_d = odd_q;
        if (vs_rise) begin
            odd_d = 1'b0;
        end else if (de_fall) begin
            odd_d = ~odd_q;
        end

        // Past the line end, odd rows keep addressing the last word so rdata repeats it.
        buf_addr  = in_range ? ADDR_W'(col_q >> 1) : ADDR_W'(BUF_DEPTH - 1);
        buf_we    = 1'b0;
        hold_d    = hold_q;
        pix_d     = '0;
        ram_sel_d = 1'b0;
        if (i_de) begin
            if (odd_q) begin
                ram_sel_d = 1'b1;
            end else if (in_range && !col_q[0] && i_valid) begin
                pix_d  = sample;
                hold_d = sample;
                buf_we = 1'b1;
            end else begin
                pix_d = hold_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q     <= '0;
            odd_q     <= 1'b0;
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            de_q      <= 1'b0;
            ram_sel_q <= 1'b0;
            hold_q    <= '0;
            pix_q     <= '0;
        end else begin
            col_q     <= col_d;
            odd_q     <= odd_d;
            vs_q      <= i_vsync;
            hs_q      <= i_hsync;
            de_q      <= i_de;
            ram_sel_q <= ram_sel_d;
            hold_q    <= hold_d;
            pix_q     <= pix_d;
        end
    end

    us_line_buf u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .addr  (buf_addr),
        .wdata (sample),
        .rdata (rd_data)
    );

    assign out_px   = ram_sel_q ? rd_data : pix_q;
    assign o_vsync  = vs_q;
    assign o_hsync  = hs_q;
    assign o_de     = de_q;
    assign o_r_data = out_px.r;
    assign o_g_data = out_px.g;
    assign o_b_data = out_px.b;

`ifdef US_ERR_CHK_EN
    logic err_q, err_set;

    assign err_set = (i_valid & ~i_de)
                   | (i_valid & i_de & (col_q[0] | odd_q))
                   | (~i_valid & i_de & ~odd_q & ~col_q[0] & in_range);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_set | (err_q & ~vs_rise);
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
